// File: rtl/uart_rx_if.sv
// uart_rx_if: byte handshake between the UART receiver and its consumer
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  modport master(output data, output valid, input ready);
  modport slave(input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver with majority vote, framing/overrun flags
module uart_rx #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      busy,
  output logic      framing_error,
  output logic      overrun
);
  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, nxt;
  logic rx_m, rx_s, s1, s2, tick, maj, at_samp, at_end, start_det, good, bad;
  logic [PW-1:0] pre;
  logic [SW-1:0] s;
  logic [2:0] idx;
  logic [7:0] shreg;
  assign tick    = pre == PW'(DIV - 1);
  assign maj     = (s1 & s2) | (s1 & rx_s) | (s2 & rx_s);
  assign at_samp = tick && s == SW'(M + 1);
  assign at_end  = tick && s == SW'(OVERSAMPLE - 1);
  assign busy    = state != IDLE;
  always_comb begin
    nxt       = state;
    start_det = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    case (state)
      IDLE:  begin start_det = !rx_s; nxt = rx_s ? IDLE : START; end
      START: nxt = (at_samp && maj) ? IDLE : at_end ? DATA : START;
      DATA:  nxt = (at_end && idx == 3'd7) ? STOP : DATA;
      STOP:  begin good = at_samp && maj; bad = at_samp && !maj; nxt = good ? IDLE : bad ? BREAK : STOP; end
      BREAK: nxt = rx_s ? IDLE : BREAK;
      default: nxt = IDLE;
    endcase
  end
  // Stop is judged at mid-bit so a following start edge is never missed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      pre           <= '0;
      s             <= '0;
      s1            <= 1'b1;
      s2            <= 1'b1;
      idx           <= '0;
      shreg         <= '0;
      bus.data      <= '0;
      bus.valid     <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= nxt;
      rx_m          <= rx;
      rx_s          <= rx_m;
      pre           <= (start_det || tick) ? '0 : pre + 1'b1;
      s             <= start_det ? '0 : !tick ? s : (s == SW'(OVERSAMPLE - 1)) ? '0 : s + 1'b1;
      s1            <= (tick && s == SW'(M - 1)) ? rx_s : s1;
      s2            <= (tick && s == SW'(M)) ? rx_s : s2;
      idx           <= state == START ? '0 : (state == DATA && at_end) ? idx + 3'd1 : idx;
      shreg         <= (state == DATA && at_samp) ? {maj, shreg[7:1]} : shreg;
      framing_error <= bad;
      overrun       <= good && bus.valid && !bus.ready;
      if (good && (!bus.valid || bus.ready)) begin
        bus.data  <= shreg;
        bus.valid <= 1'b1;
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 32 clocks per bit
module tb_uart_rx;
  logic clock = 1'b0, reset = 1'b0, rx = 1'b1;
  logic busy, framing_error, overrun;
  int n_cmp = 0, n_err = 0, fe_cnt = 0, ov_cnt = 0, fe0, ov0;
  logic pv = 1'b0;
  logic [7:0] pd = '0;
  logic [7:0] q[$];
  uart_rx_if bus();
  uart_rx #(.CLOCK_FREQ(3200000), .BAUD_RATE(100000), .OVERSAMPLE(16)) dut (
    .clock(clock), .reset(reset), .rx(rx), .bus(bus),
    .busy(busy), .framing_error(framing_error), .overrun(overrun)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // A delivery is valid rising, or a new byte replacing a held one
  always @(negedge clock) begin
    logic [8:0] e;
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (bus.valid && (!pv || bus.data != pd)) begin
      e = q.size() != 0 ? {1'b0, q.pop_front()} : 9'h100;
      check("rx_byte", {24'h0, bus.data}, {23'h0, e});
    end
    pv = bus.valid;
    pd = bus.data;
  end
  task automatic send(input logic [7:0] b, input logic stop, input int rdy_c, input int glitch_i, input int abort_i);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < 32; c++) begin
        @(negedge clock);
        if (c == 0) rx = f[i];
        if (i == glitch_i && c == 15) rx = ~f[i];
        if (i == glitch_i && c == 17) rx = f[i];
        if (i == 9 && c == rdy_c) bus.ready = 1'b1;
        if (i == abort_i && c == 16) begin
          check("busy_mid", {31'h0, busy}, 32'd1);
          reset = 1'b0;
          rx = 1'b1;
          return;
        end
      end
  endtask
  task automatic settle(input string tag, input int fe_exp, input int ov_exp);
    repeat (12) @(negedge clock);
    check({tag, "_q"}, q.size(), 0);
    check({tag, "_fe"}, fe_cnt - fe0, fe_exp);
    check({tag, "_ov"}, ov_cnt - ov0, ov_exp);
    check({tag, "_busy"}, {31'h0, busy}, 0);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
  endtask
  initial begin
    bus.ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_data", {24'h0, bus.data}, 0);
    check("rst_valid", {31'h0, bus.valid}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_flags", {30'h0, framing_error, overrun}, 0);
    reset = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    repeat (40) @(negedge clock);
    q.push_back(8'h55); send(8'h55, 1'b1, -1, -1, -1);
    q.push_back(8'hA3); send(8'hA3, 1'b1, -1, -1, -1);
    settle("basic", 0, 0);
    rx = 1'b0;
    repeat (8) @(negedge clock);
    rx = 1'b1;
    repeat (24) @(negedge clock);
    check("false_busy", {31'h0, busy}, 0);
    settle("false", 0, 0);
    send(8'h3C, 1'b0, -1, -1, -1);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    check("fe_valid", {31'h0, bus.valid}, 0);
    settle("frame", 1, 0);
    q.push_back(8'h81); send(8'h81, 1'b1, -1, -1, -1);
    settle("recover", 0, 0);
    bus.ready = 1'b0;
    q.push_back(8'h11); send(8'h11, 1'b1, -1, -1, -1);
    send(8'h22, 1'b1, -1, -1, -1);
    check("ovr_valid", {31'h0, bus.valid}, 1);
    check("ovr_data", {24'h0, bus.data}, 32'h11);
    bus.ready = 1'b1;
    @(negedge clock);
    check("ack_valid", {31'h0, bus.valid}, 0);
    check("ack_data", {24'h0, bus.data}, 32'h11);
    settle("overrun", 0, 1);
    bus.ready = 1'b0;
    q.push_back(8'h5A); send(8'h5A, 1'b1, -1, -1, -1);
    q.push_back(8'h22); send(8'h22, 1'b1, 22, -1, -1);
    check("race_data", {24'h0, bus.data}, 32'h22);
    settle("race", 0, 0);
    send(8'hF0, 1'b1, -1, -1, 5);
    repeat (3) @(negedge clock);
    check("rr_data", {24'h0, bus.data}, 0);
    check("rr_valid", {31'h0, bus.valid}, 0);
    check("rr_busy", {31'h0, busy}, 0);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    q.push_back(8'h0F); send(8'h0F, 1'b1, -1, 3, -1);
    settle("glitch", 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
